i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, 7'h50, 7-bit I2C address the block responds to.
REQ-002 SHALL have parameter NUM_REGS, 4, number of 8-bit registers; legal range 2..256.
REQ-003 SHALL have parameter PTR_W, $clog2(NUM_REGS), register pointer width.
REQ-004 clk  input  1  system clock; at least 8x the SCL frequency.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 scl_in  input  1  SCL pin sample, asynchronous to clk.
REQ-007 sda_in  input  1  SDA pin sample, asynchronous to clk.
REQ-008 sda_oe  output  1  1 pulls SDA low; 0 releases SDA (pad pull-up gives 1).
REQ-009 host_we  input  1  host register write strobe.
REQ-010 host_addr  input  PTR_W  host register index for read and write.
REQ-011 host_wdata  input  8  host write data.
REQ-012 host_rdata  output  8  combinational read of regs[host_addr].
REQ-013 i2c_wr_pulse  output  1  one-cycle strobe after each byte an I2C master writes.
REQ-014 i2c_wr_idx  output  PTR_W  register index of the last I2C write.
REQ-015 busy  output  1  high from an address-matched START until STOP.

Function
REQ-016 SHALL pass scl_in and sda_in through 2-flop synchronisers; all detection SHALL use the synchronised values and their one-cycle-delayed copies.
REQ-017 START = synchronised SDA falls while SCL high; STOP = SDA rises while SCL high; both SHALL be recognised in any state, including mid-byte.
REQ-018 Data bits SHALL be sampled on the SCL rising edge, MSB first; sda_oe SHALL change only on the cycle after an SCL falling edge is detected.
REQ-019 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-020 START -> ADDR from any state (repeated START included); STOP -> IDLE from any state with sda_oe=0.
REQ-021 ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR -> ADDR_ACK (drive 0 for the 9th clock), otherwise -> IGNORE (sda_oe held 0).
REQ-022 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RD_DATA starting at the current pointer.
REQ-023 PTR: received byte < NUM_REGS loads the pointer and is ACKed (-> WR_DATA); byte >= NUM_REGS is NACKed (-> IGNORE), and the pointer is unchanged.
REQ-024 WR_DATA: after 8 bits write regs[ptr], pulse i2c_wr_pulse, set i2c_wr_idx=ptr, ACK, then increment ptr.
REQ-025 RD_DATA: shift out regs[ptr], latched at byte start; in RD_ACK sample master bit: ACK -> increment ptr, next byte; NACK -> IGNORE.
REQ-026 Pointer increment SHALL wrap from NUM_REGS-1 to 0.
REQ-027 The pointer SHALL persist across transactions, so a write of a pointer alone followed by a repeated-START read reads from that pointer.
REQ-028 Simultaneous host_we and an I2C write to the same index in one cycle: the I2C write SHALL win.
REQ-029 Host writes to regs[ptr] during RD_DATA SHALL NOT alter the byte already latched for transmission.

Reset
REQ-030 rst_n low SHALL immediately set state=IDLE, sda_oe=0, busy=0, i2c_wr_pulse=0, i2c_wr_idx=0, pointer=0, all regs=8'h00, and synchronisers to 1.
REQ-031 Reset asserted mid-transaction SHALL release SDA within the same cycle (asynchronous path), and after release the block SHALL wait for a new START.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration and the I2C constants (ACK=0, NACK=1, RW_READ=1).
REQ-033 A single sub-module i2c_line_sync SHALL hold the synchronisers and the START/STOP/SCL-rise/SCL-fall detectors.

Verification (SLAVE_ADDR=7'h50, NUM_REGS=4)
REQ-034 Bus write 0xA0, 0x01, 0xA8, 0x39, STOP -> four ACKs, regs[1]=A8, regs[2]=39, two i2c_wr_pulse with idx 1 then 2.
REQ-035 Write 0xA0, 0x01; repeated START 0xA1; master ACK then NACK -> slave sends A8 then 39, and sda_oe=0 after the NACK.
REQ-036 Address byte 0xA4 followed by 8 data clocks -> sda_oe stays 0 throughout and busy stays 0.
REQ-037 Write 0xA0, 0x03, 0x11, 0x22 -> regs[3]=11, regs[0]=22 (wrap); pointer byte 0x04 -> NACK and regs unchanged.
REQ-038 rst_n pulsed low while the slave drives bit 3 of a read byte -> sda_oe=0 in the same cycle; the next START with 0xA1 reads regs[0]=00.

Source files
------------

// File: rtl/i2c_slave_regs_pkg.sv
// Shared definitions for the I2C register slave.
// Holds the FSM state enumeration and the I2C bit-level constants.
package i2c_slave_regs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers and bus-event detectors.
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   scl_in/sda_in raw pin samples (asynchronous to clk)
//   sda           synchronised SDA
//   start_det     SDA fell while SCL high
//   stop_det      SDA rose while SCL high
//   scl_rise      synchronised SCL rising edge
//   scl_fall      synchronised SCL falling edge
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic start_det,
  output logic stop_det,
  output logic scl_rise,
  output logic scl_fall
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;
  logic       scl;

  // Reset to the idle bus level so no edge is seen on reset release
  // while the bus is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl = scl_sync[1];
  assign sda = sda_sync[1];

  // SCL must be high on both samples so an SDA change racing an SCL
  // edge is not mistaken for START/STOP.
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing NUM_REGS 8-bit registers, also host accessible.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   scl_in, sda_in    raw I2C pin samples
//   sda_oe            1 pulls SDA low
//   host_we/addr/wdata host register write port
//   host_rdata        combinational read of regs[host_addr]
//   i2c_wr_pulse      one-cycle strobe per byte written over I2C
//   i2c_wr_idx        register index of last I2C write
//   busy              address-matched transaction in progress
//
// state       | meaning
// ST_IDLE     | waiting for START
// ST_ADDR     | receiving address + R/W byte
// ST_ADDR_ACK | driving ACK for matched address
// ST_PTR      | receiving register pointer byte
// ST_PTR_ACK  | driving ACK for valid pointer
// ST_WR_DATA  | receiving a data byte
// ST_WR_ACK   | driving ACK for a written byte
// ST_RD_DATA  | shifting out latched register byte
// ST_RD_ACK   | sampling master ACK/NACK
// ST_IGNORE   | not addressed / NACKed; wait for START or STOP
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int          NUM_REGS   = 4,
  parameter int          PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             i2c_wr_pulse,
  output logic [PTR_W-1:0] i2c_wr_idx,
  output logic             busy
);

  logic sda, start_det, stop_det, scl_rise, scl_fall;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda),
    .start_det (start_det),
    .stop_det  (stop_det),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall)
  );

  i2c_state_e       state, state_n;
  logic [3:0]       bit_cnt, cnt_n;
  logic [7:0]       shreg, sh_n;
  logic [7:0]       tx, tx_n;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic [PTR_W-1:0] idx_n;
  logic             m_ack, mack_n;
  logic             oe_n, busy_n, pulse_n, i2c_we;
  logic [7:0]       regs [NUM_REGS];

  assign host_rdata = regs[host_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx           <= '0;
      ptr          <= '0;
      m_ack        <= I2C_NACK;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      i2c_wr_pulse <= 1'b0;
      i2c_wr_idx   <= '0;
    end else begin
      state        <= state_n;
      bit_cnt      <= cnt_n;
      shreg        <= sh_n;
      tx           <= tx_n;
      ptr          <= ptr_n;
      m_ack        <= mack_n;
      sda_oe       <= oe_n;
      busy         <= busy_n;
      i2c_wr_pulse <= pulse_n;
      i2c_wr_idx   <= idx_n;
    end
  end

  // The I2C write is applied after the host write so it wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (host_we) regs[host_addr] <= host_wdata;
      if (i2c_we)  regs[ptr]       <= shreg;
    end
  end

  // All sda_oe updates other than STOP/START happen on scl_fall, so the
  // pin only moves in the cycle after a detected falling edge.
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    tx_n    = tx;
    ptr_n   = ptr;
    mack_n  = m_ack;
    oe_n    = sda_oe;
    busy_n  = busy;
    pulse_n = 1'b0;
    idx_n   = i2c_wr_idx;
    i2c_we  = 1'b0;
    ptr_inc = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);

    if (stop_det) begin
      state_n = ST_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n = ST_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          sh_n  = {shreg[6:0], sda};
          cnt_n = bit_cnt + 4'd1;
        end
        ST_RD_DATA: cnt_n  = bit_cnt + 4'd1;
        ST_RD_ACK:  mack_n = sda;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ST_ADDR: begin
          if (bit_cnt == 4'd8) begin
            cnt_n = '0;
            if (shreg[7:1] == SLAVE_ADDR) begin
              state_n = ST_ADDR_ACK;
              oe_n    = 1'b1;
              busy_n  = 1'b1;
            end else begin
              state_n = ST_IGNORE;
              oe_n    = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          cnt_n = '0;
          if (shreg[0] == I2C_RW_READ) begin
            state_n = ST_RD_DATA;
            tx_n    = regs[ptr];
            oe_n    = ~regs[ptr][7];
          end else begin
            state_n = ST_PTR;
            oe_n    = 1'b0;
          end
        end
        ST_PTR: begin
          if (bit_cnt == 4'd8) begin
            cnt_n = '0;
            if ({1'b0, shreg} < 9'(NUM_REGS)) begin
              ptr_n   = shreg[PTR_W-1:0];
              state_n = ST_PTR_ACK;
              oe_n    = 1'b1;
            end else begin
              state_n = ST_IGNORE;
              oe_n    = 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          state_n = ST_WR_DATA;
          cnt_n   = '0;
          oe_n    = 1'b0;
        end
        ST_WR_DATA: begin
          if (bit_cnt == 4'd8) begin
            i2c_we  = 1'b1;
            pulse_n = 1'b1;
            idx_n   = ptr;
            ptr_n   = ptr_inc;
            state_n = ST_WR_ACK;
            cnt_n   = '0;
            oe_n    = 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (bit_cnt == 4'd8) begin
            state_n = ST_RD_ACK;
            cnt_n   = '0;
            oe_n    = 1'b0;
          end else begin
            oe_n = ~tx[6];
            tx_n = {tx[6:0], 1'b0};
          end
        end
        ST_RD_ACK: begin
          cnt_n = '0;
          if (m_ack == I2C_NACK) begin
            state_n = ST_IGNORE;
            oe_n    = 1'b0;
          end else begin
            ptr_n   = ptr_inc;
            tx_n    = regs[ptr_inc];
            oe_n    = ~regs[ptr_inc][7];
            state_n = ST_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
module tb_i2c_slave_regs;

  localparam int Q  = 6;
  localparam int NR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic       host_we = 1'b0;
  logic [1:0] host_addr = 2'd0;
  logic [7:0] host_wdata = 8'd0;
  logic [7:0] host_rdata;
  logic       i2c_wr_pulse;
  logic [1:0] i2c_wr_idx;
  logic       busy;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .NUM_REGS(4), .PTR_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe       (sda_oe),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .i2c_wr_pulse (i2c_wr_pulse),
    .i2c_wr_idx   (i2c_wr_idx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [7:0] data; } wr_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_regs [NR];
  int         model_ptr = 0;
  wr_t        wr_q [$];
  wr_t        w_cur;
  logic [7:0] rd_log [$];
  bit         cmp_hold = 1'b1;
  bit         expect_quiet = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (i2c_wr_pulse) begin
        if (wr_q.size() == 0) begin
          check("wr_pulse_unexpected", {31'd0, i2c_wr_pulse}, 32'd0);
        end else begin
          w_cur = wr_q.pop_front();
          check("wr_idx", {30'd0, i2c_wr_idx}, w_cur.idx);
          model_regs[w_cur.idx] = w_cur.data;
        end
      end
      if (!cmp_hold) check("host_rdata", host_rdata, model_regs[host_addr]);
      if (expect_quiet) begin
        check("quiet_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("quiet_busy", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a[1:0]; host_wdata = d;
    @(posedge clk);
    #1;
    host_we = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic peek(input int a, input logic [7:0] e, input string nm);
    @(negedge clk);
    host_addr = a[1:0];
    #1;
    check(nm, host_rdata, e);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
    check("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    seen = sda_line;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] v);
    logic s;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      v = {v[6:0], s};
    end
    clock_bit(mack, s);
  endtask

  task automatic txn_write(input logic [7:0] p, input int n, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [7:0] d2, input bit do_stop);
    logic a;
    logic [7:0] d;
    bus_start;
    write_byte(8'hA0, a);
    check("addr_w_ack", {31'd0, a}, 32'd0);
    check("busy_in_txn", {31'd0, busy}, 32'd1);
    write_byte(p, a);
    if (p < NR) begin
      check("ptr_ack", {31'd0, a}, 32'd0);
      model_ptr = p;
      for (int i = 0; i < n; i++) begin
        d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
        wr_q.push_back('{model_ptr, d});
        write_byte(d, a);
        check("data_ack", {31'd0, a}, 32'd0);
        model_ptr = (model_ptr + 1) % NR;
      end
    end else begin
      check("ptr_nack", {31'd0, a}, 32'd1);
    end
    if (do_stop) bus_stop;
  endtask

  task automatic txn_read(input bit set_ptr, input logic [7:0] p, input int n, input bit poke);
    logic a;
    logic [7:0] got, exp;
    if (set_ptr) txn_write(p, 0, 8'd0, 8'd0, 8'd0, 1'b0);
    bus_start;
    write_byte(8'hA1, a);
    check("addr_r_ack", {31'd0, a}, 32'd0);
    for (int i = 0; i < n; i++) begin
      exp = model_regs[model_ptr];
      if (poke && i == 0) host_write(model_ptr, ~exp);
      read_byte(i == n - 1, got);
      rd_log.push_back(got);
      check("rd_data", got, exp);
      if (i != n - 1) model_ptr = (model_ptr + 1) % NR;
    end
    tick(2);
    check("oe_after_nack", {31'd0, sda_oe}, 32'd0);
    bus_stop;
  endtask

  task automatic txn_bad_addr(input logic [7:0] ab);
    logic a, s;
    expect_quiet = 1'b1;
    bus_start;
    write_byte(ab, a);
    check("bad_addr_nack", {31'd0, a}, 32'd1);
    for (int i = 0; i < 8; i++) clock_bit(1'($urandom), s);
    bus_stop;
    expect_quiet = 1'b0;
  endtask

  task automatic txn_collide;
    logic a;
    bit got_pulse;
    bus_start;
    write_byte(8'hA0, a);
    check("col_addr_ack", {31'd0, a}, 32'd0);
    write_byte(8'h02, a);
    check("col_ptr_ack", {31'd0, a}, 32'd0);
    model_ptr = 2;
    wr_q.push_back('{2, 8'h5A});
    cmp_hold  = 1'b1;
    got_pulse = 1'b0;
    fork
      write_byte(8'h5A, a);
      begin
        host_addr = 2'd2; host_wdata = 8'hC3; host_we = 1'b1;
        for (int k = 0; k < 2000 && !got_pulse; k++) begin
          @(negedge clk);
          if (i2c_wr_pulse) got_pulse = 1'b1;
        end
        host_we = 1'b0;
      end
    join
    check("col_pulse_seen", {31'd0, got_pulse}, 32'd1);
    check("col_data_ack", {31'd0, a}, 32'd0);
    peek(2, 8'h5A, "col_i2c_wins");
    cmp_hold  = 1'b0;
    model_ptr = 3;
    bus_stop;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, s;
    logic [7:0] got;
    int kind;
    logic [6:0] ad;

    for (int i = 0; i < NR; i++) model_regs[i] = 8'h00;
    rst_n = 1'b0;
    tick(3);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_pulse", {31'd0, i2c_wr_pulse}, 32'd0);
    check("rst_wr_idx", {30'd0, i2c_wr_idx}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < NR; i++) peek(i, 8'h00, "rst_reg");
    cmp_hold = 1'b0;

    // Plain write of two bytes from pointer 1.
    txn_write(8'h01, 2, 8'hA8, 8'h39, 8'h00, 1'b1);
    peek(1, 8'hA8, "w_reg1");
    peek(2, 8'h39, "w_reg2");
    check("w_last_idx", {30'd0, i2c_wr_idx}, 32'd2);

    // Pointer-only write then repeated-START read of two bytes.
    rd_log.delete();
    txn_read(1'b1, 8'h01, 2, 1'b0);
    check("rs_byte0", rd_log[0], 8'hA8);
    check("rs_byte1", rd_log[1], 8'h39);

    // Pointer wrap, then an out-of-range pointer.
    txn_write(8'h03, 2, 8'h11, 8'h22, 8'h00, 1'b1);
    txn_write(8'h04, 1, 8'hEE, 8'h00, 8'h00, 1'b1);
    peek(0, 8'h22, "wrap_reg0");
    peek(1, 8'hA8, "wrap_reg1");
    peek(2, 8'h39, "wrap_reg2");
    peek(3, 8'h11, "wrap_reg3");

    txn_bad_addr(8'hA4);
    txn_collide;

    // Host write during read must not disturb the latched byte.
    txn_read(1'b1, 8'h00, 2, 1'b1);

    // Reset while the slave drives bit 3 of a read byte.
    host_write(model_ptr, 8'h42);
    bus_start;
    write_byte(8'hA1, a);
    check("r38_addr_ack", {31'd0, a}, 32'd0);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
    check("r38_bit3_driven", {31'd0, sda_oe}, 32'd1);
    cmp_hold = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("r38_async_oe", {31'd0, sda_oe}, 32'd0);
    check("r38_busy", {31'd0, busy}, 32'd0);
    check("r38_wr_idx", {30'd0, i2c_wr_idx}, 32'd0);
    for (int i = 0; i < NR; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    wr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick(Q);
    cmp_hold = 1'b0;
    bus_start;
    write_byte(8'hA1, a);
    check("r38_re_ack", {31'd0, a}, 32'd0);
    read_byte(1'b1, got);
    check("r38_read0", got, 8'h00);
    bus_stop;

    // Randomized traffic against the model.
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: txn_write(8'($urandom_range(0, 5)), $urandom_range(1, 3),
                     8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        1: txn_read(1'b1, 8'($urandom_range(0, 3)), $urandom_range(1, 3), 1'($urandom));
        2: txn_read(1'b0, 8'h00, $urandom_range(1, 3), 1'b0);
        default: begin
          ad = 7'($urandom);
          if (ad == 7'h50) ad = 7'h51;
          txn_bad_addr({ad, 1'($urandom)});
        end
      endcase
      if ($urandom_range(0, 1) == 1) host_write($urandom_range(0, 3), 8'($urandom));
      tick(Q);
    end

    tick(4);
    check("wr_q_drained", wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
